// File: rtl/proc_sequencer_pkg.sv
// rtl/proc_sequencer_pkg.sv - shared state encodings and opcode/funct constants
package prj_definition;

    typedef enum logic [2:0] {
        PROC_IDLE   = 3'd0,
        PROC_FETCH  = 3'd1,
        PROC_DECODE = 3'd2,
        PROC_EXE    = 3'd3,
        PROC_MEM    = 3'd4,
        PROC_WB     = 3'd5
    } proc_state_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0a;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_PUSH  = 6'h1b;
    localparam logic [5:0] OP_POP   = 6'h1c;
    localparam logic [5:0] OP_MULI  = 6'h1d;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_JR    = 6'h08;

endpackage

// File: rtl/proc_insn_class.sv
// rtl/proc_insn_class.sv - classifies opcode/funct into memory and write-back properties
module proc_insn_class
    import prj_definition::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic       needs_mem,
    output logic       is_load,
    output logic       is_store,
    output logic       writes_rf
);

    // Pure decode of the latched instruction; unknown opcodes neither touch memory nor write back
    always_comb begin
        is_load   = (opcode == OP_LW) || (opcode == OP_POP);
        is_store  = (opcode == OP_SW) || (opcode == OP_PUSH);
        needs_mem = is_load || is_store;
        writes_rf = 1'b0;
        case (opcode)
            OP_RTYPE: writes_rf = (funct != FN_JR);
            OP_LW, OP_POP, OP_JAL, OP_ADDI, OP_MULI,
            OP_ANDI, OP_ORI, OP_SLTI, OP_LUI: writes_rf = 1'b1;
            default:  writes_rf = 1'b0;
        endcase
    end

endmodule

// File: rtl/proc_sequencer.sv
// rtl/proc_sequencer.sv - FETCH/DECODE/EXE/MEM/WB sequencer; optional memory timeout via PROC_SEQ_MEM_TIMEOUT_EN
module proc_sequencer
    import prj_definition::*;
#(
    parameter int DATA_W      = 32,
    parameter int CNT_W       = 32,
    parameter int SKIP_MEM    = 1,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [DATA_W-1:0] INSTRUCTION,
    input  logic              MEM_ACK,
    input  logic              HALT,
    output logic [2:0]        STATE,
    output logic              MEM_READ,
    output logic              MEM_WRITE,
    output logic              IR_LOAD,
    output logic              PC_LOAD,
    output logic              RF_WRITE,
    output logic [CNT_W-1:0]  INSN_COUNT,
    output logic [CNT_W-1:0]  STALL_COUNT,
    output logic              MEM_ERR
);

    proc_state_e      state_q;
    proc_state_e      state_d;
    logic [5:0]       opcode_q;
    logic [5:0]       funct_q;
    logic             needs_mem;
    logic             is_load;
    logic             is_store;
    logic             writes_rf;
    logic             wait_cyc;
    logic             timeout;
    logic [CNT_W-1:0] insn_cnt_q;
    logic [CNT_W-1:0] stall_cnt_q;
    logic             unused_insn_bits;

    // Only opcode and funct fields steer the sequence; the operand fields belong to the datapath
    assign unused_insn_bits = ^INSTRUCTION[DATA_W-7:6];

    proc_insn_class u_insn_class (
        .opcode    (opcode_q),
        .funct     (funct_q),
        .needs_mem (needs_mem),
        .is_load   (is_load),
        .is_store  (is_store),
        .writes_rf (writes_rf)
    );

    // Strobes depend only on the current state, the latched opcode and the live ACK
    always_comb begin
        MEM_READ  = (state_q == PROC_FETCH) || ((state_q == PROC_MEM) && is_load);
        MEM_WRITE = (state_q == PROC_MEM) && is_store;
        IR_LOAD   = (state_q == PROC_FETCH) && MEM_ACK;
        PC_LOAD   = (state_q == PROC_WB);
        RF_WRITE  = (state_q == PROC_WB) && writes_rf;
    end

    // A wait cycle is any cycle with an outstanding request that memory did not complete
    assign wait_cyc = (MEM_READ || MEM_WRITE) && !MEM_ACK;

`ifdef PROC_SEQ_MEM_TIMEOUT_EN
    localparam int WAIT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [WAIT_W-1:0] wait_cnt_q;
    logic              mem_err_q;

    // The TIMEOUT_CYC-th consecutive wait cycle of one request aborts the instruction
    assign timeout = wait_cyc && (wait_cnt_q == WAIT_W'(TIMEOUT_CYC - 1));

    // Counts consecutive waits; restarts whenever the request completes or the state moves on
    always_ff @(posedge CLK) begin
        if (!RST) begin
            wait_cnt_q <= '0;
        end else if (!wait_cyc || (state_d != state_q)) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
        end
    end

    // Error flag stays set until reset so software can see that an access was abandoned
    always_ff @(posedge CLK) begin
        if (!RST) begin
            mem_err_q <= 1'b0;
        end else if (timeout) begin
            mem_err_q <= 1'b1;
        end
    end

    assign MEM_ERR = mem_err_q;
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = (TIMEOUT_CYC != 0);
    assign timeout            = 1'b0;
    assign MEM_ERR            = 1'b0;
`endif

    // Next-state selection; a timeout overrides whatever the current state would do
    always_comb begin
        state_d = state_q;
        case (state_q)
            PROC_IDLE:   if (!HALT) state_d = PROC_FETCH;
            PROC_FETCH:  if (MEM_ACK) state_d = PROC_DECODE;
            PROC_DECODE: state_d = PROC_EXE;
            PROC_EXE:    state_d = (needs_mem || (SKIP_MEM == 0)) ? PROC_MEM : PROC_WB;
            PROC_MEM:    if (!needs_mem || MEM_ACK) state_d = PROC_WB;
            PROC_WB:     state_d = HALT ? PROC_IDLE : PROC_FETCH;
            default:     state_d = PROC_IDLE;
        endcase
        if (timeout) begin
            state_d = PROC_IDLE;
        end
    end

    // State register
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q <= PROC_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Opcode and funct are captured on the same edge the datapath latches the instruction
    always_ff @(posedge CLK) begin
        if (!RST) begin
            opcode_q <= '0;
            funct_q  <= '0;
        end else if (IR_LOAD) begin
            opcode_q <= INSTRUCTION[DATA_W-1 -: 6];
            funct_q  <= INSTRUCTION[5:0];
        end
    end

    // Retire counter wraps; stall counter sticks at all-ones rather than wrapping to a misleading value
    always_ff @(posedge CLK) begin
        if (!RST) begin
            insn_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (state_q == PROC_WB) begin
                insn_cnt_q <= insn_cnt_q + 1'b1;
            end
            if (wait_cyc && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
        end
    end

    assign STATE       = state_q;
    assign INSN_COUNT  = insn_cnt_q;
    assign STALL_COUNT = stall_cnt_q;

endmodule

// File: tb/tb_proc_sequencer.sv
// tb/tb_proc_sequencer.sv - self-checking bench for proc_sequencer (honours PROC_SEQ_MEM_TIMEOUT_EN)
module tb_proc_sequencer;
    import prj_definition::*;

    localparam int TO = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [31:0] insn [2];
    logic        ack  [2];
    logic        halt [2];
    logic [2:0]  st   [2];
    logic        mrd  [2];
    logic        mwr  [2];
    logic        irl  [2];
    logic        pcl  [2];
    logic        rfw  [2];
    logic        err  [2];
    logic [31:0] ic0, sc0;
    logic [2:0]  ic1, sc1;

    int n_chk  = 0;
    int n_pass = 0;

    // instance 0: MEM skipped for non-memory ops, 32-bit counters
    proc_sequencer #(.DATA_W(32), .CNT_W(32), .SKIP_MEM(1), .TIMEOUT_CYC(TO)) u_skip (
        .CLK(clk), .RST(rst), .INSTRUCTION(insn[0]), .MEM_ACK(ack[0]), .HALT(halt[0]),
        .STATE(st[0]), .MEM_READ(mrd[0]), .MEM_WRITE(mwr[0]), .IR_LOAD(irl[0]),
        .PC_LOAD(pcl[0]), .RF_WRITE(rfw[0]), .INSN_COUNT(ic0), .STALL_COUNT(sc0),
        .MEM_ERR(err[0])
    );

    // instance 1: always through MEM, 3-bit counters to reach wrap and saturation
    proc_sequencer #(.DATA_W(32), .CNT_W(3), .SKIP_MEM(0), .TIMEOUT_CYC(TO)) u_full (
        .CLK(clk), .RST(rst), .INSTRUCTION(insn[1]), .MEM_ACK(ack[1]), .HALT(halt[1]),
        .STATE(st[1]), .MEM_READ(mrd[1]), .MEM_WRITE(mwr[1]), .IR_LOAD(irl[1]),
        .PC_LOAD(pcl[1]), .RF_WRITE(rfw[1]), .INSN_COUNT(ic1), .STALL_COUNT(sc1),
        .MEM_ERR(err[1])
    );

    // ---------------- reference model ----------------
    logic [2:0]      m_st  [2];
    logic [5:0]      m_op  [2];
    logic [5:0]      m_fn  [2];
    longint unsigned m_ic  [2];
    longint unsigned m_sc  [2];
    bit              m_err [2];
    int              m_wait[2];
    bit              m_valid = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic bit f_load(input logic [5:0] op);
        return (op == 6'h23) || (op == 6'h1c);
    endfunction

    function automatic bit f_store(input logic [5:0] op);
        return (op == 6'h2b) || (op == 6'h1b);
    endfunction

    function automatic bit f_wrf(input logic [5:0] op, input logic [5:0] fn);
        if (op == 6'h00) return fn != 6'h08;
        return op inside {6'h23, 6'h1c, 6'h03, 6'h08, 6'h1d, 6'h0c, 6'h0d, 6'h0a, 6'h0f};
    endfunction

    function automatic longint unsigned cmax(input int i);
        return (i == 0) ? 64'hFFFF_FFFF : 64'd7;
    endfunction

    function automatic bit e_rd(input int i);
        return (m_st[i] == PROC_FETCH) || ((m_st[i] == PROC_MEM) && f_load(m_op[i]));
    endfunction

    function automatic bit e_wr(input int i);
        return (m_st[i] == PROC_MEM) && f_store(m_op[i]);
    endfunction

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [5:0] fn);
        return {op, 20'h12345, fn};
    endfunction

    task automatic model_step(input int i);
        logic [2:0] nxt;
        bit         waiting;
        waiting = (e_rd(i) || e_wr(i)) && !ack[i];
        if (!rst) begin
            m_st[i] = PROC_IDLE; m_op[i] = '0; m_fn[i] = '0;
            m_ic[i] = 0; m_sc[i] = 0; m_err[i] = 1'b0; m_wait[i] = 0;
            m_valid = 1'b1;
            return;
        end
        nxt = m_st[i];
        case (m_st[i])
            PROC_IDLE:   if (!halt[i]) nxt = PROC_FETCH;
            PROC_FETCH:  if (ack[i]) nxt = PROC_DECODE;
            PROC_DECODE: nxt = PROC_EXE;
            PROC_EXE:    nxt = (f_load(m_op[i]) || f_store(m_op[i]) || i == 1) ? PROC_MEM : PROC_WB;
            PROC_MEM:    if (!(f_load(m_op[i]) || f_store(m_op[i])) || ack[i]) nxt = PROC_WB;
            PROC_WB:     nxt = halt[i] ? PROC_IDLE : PROC_FETCH;
            default:     nxt = PROC_IDLE;
        endcase
        if (m_st[i] == PROC_FETCH && ack[i]) begin
            m_op[i] = insn[i][31:26];
            m_fn[i] = insn[i][5:0];
        end
        if (m_st[i] == PROC_WB) m_ic[i] = (m_ic[i] + 1) & cmax(i);
        if (waiting && m_sc[i] != cmax(i)) m_sc[i] = m_sc[i] + 1;
`ifdef PROC_SEQ_MEM_TIMEOUT_EN
        if (waiting && (m_wait[i] + 1 >= TO)) begin
            m_err[i] = 1'b1;
            nxt      = PROC_IDLE;
        end
`endif
        m_wait[i] = (waiting && nxt == m_st[i]) ? m_wait[i] + 1 : 0;
        m_st[i]   = nxt;
    endtask

    // model advances on the active edge using the inputs that edge saw
    initial forever begin
        @(posedge clk);
        for (int i = 0; i < 2; i++) model_step(i);
    end

    // cycle-by-cycle comparison of both instances against the model
    initial forever begin
        @(negedge clk);
        if (m_valid) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("i%0d STATE", i), st[i], m_st[i]);
                chk($sformatf("i%0d MEM_READ", i), mrd[i], e_rd(i));
                chk($sformatf("i%0d MEM_WRITE", i), mwr[i], e_wr(i));
                chk($sformatf("i%0d IR_LOAD", i), irl[i], (m_st[i] == PROC_FETCH) && ack[i]);
                chk($sformatf("i%0d PC_LOAD", i), pcl[i], m_st[i] == PROC_WB);
                chk($sformatf("i%0d RF_WRITE", i), rfw[i], (m_st[i] == PROC_WB) && f_wrf(m_op[i], m_fn[i]));
                chk($sformatf("i%0d MEM_ERR", i), err[i], m_err[i]);
                chk($sformatf("i%0d INSN_COUNT", i), (i == 0) ? 64'(ic0) : 64'(ic1), m_ic[i]);
                chk($sformatf("i%0d STALL_COUNT", i), (i == 0) ? 64'(sc0) : 64'(sc1), m_sc[i]);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            halt[i] = 1'b1; ack[i] = 1'b0; insn[i] = '0;
        end
        tick();
        tick();
        rst = 1'b1;
    endtask

    logic [2:0] s_st [16];
    logic       s_a  [16];
    logic       s_b  [16];
    int         cnt_a, cnt_b, pulses;
    bit         ack_pat [11];

    initial begin
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            halt[i] = 1'b1; ack[i] = 1'b0; insn[i] = '0;
        end

        // reset values and addi through the skip path
        do_reset();
        @(negedge clk);
        chk("reset STATE", st[0], PROC_IDLE);
        chk("reset strobes", {mrd[0], mwr[0], irl[0], pcl[0], rfw[0], err[0]}, 0);
        chk("reset counters", {ic0, sc0}, 0);
        tick();
        halt[0] = 1'b0; ack[0] = 1'b1; insn[0] = mk(6'h08, 6'h00);
        tick();
        halt[0] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            s_st[k] = st[0]; s_a[k] = rfw[0]; s_b[k] = pcl[0];
        end
        chk("addi seq FETCH", s_st[0], PROC_FETCH);
        chk("addi seq DECODE", s_st[1], PROC_DECODE);
        chk("addi seq EXE", s_st[2], PROC_EXE);
        chk("addi seq WB", s_st[3], PROC_WB);
        chk("addi seq IDLE", s_st[4], PROC_IDLE);
        chk("addi RF_WRITE in WB", {s_a[2], s_a[3], s_b[3]}, 3'b011);
        chk("addi INSN_COUNT", ic0, 1);

        // lw with 3 FETCH waits and 2 MEM waits
        do_reset();
        tick();
        halt[0] = 1'b0; insn[0] = mk(6'h23, 6'h00);
        ack_pat = '{0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0};
        cnt_a = 0; cnt_b = 0; s_a[0] = 1'b0;
        for (int c = 0; c < 11; c++) begin
            tick();
            ack[0] = ack_pat[c]; halt[0] = 1'b1;
            @(negedge clk);
            if (mrd[0] && st[0] == PROC_FETCH) cnt_a++;
            if (mrd[0] && st[0] == PROC_MEM) cnt_b++;
            if (rfw[0]) s_a[0] = 1'b1;
        end
        chk("lw FETCH read cycles", cnt_a, 4);
        chk("lw MEM read cycles", cnt_b, 3);
        chk("lw STALL_COUNT", sc0, 5);
        chk("lw RF_WRITE seen", s_a[0], 1);
        chk("lw INSN_COUNT", ic0, 1);

        // sw then beq through MEM on the no-skip instance
        tick();
        halt[1] = 1'b0; ack[1] = 1'b1; insn[1] = mk(6'h2b, 6'h00);
        cnt_a = 0;
        for (int c = 0; c < 11; c++) begin
            tick();
            insn[1] = (c < 5) ? mk(6'h2b, 6'h00) : mk(6'h04, 6'h00);
            halt[1] = (c >= 5);
            @(negedge clk);
            s_st[c] = st[1]; s_a[c] = rfw[1]; s_b[c] = pcl[1];
            if (mwr[1]) cnt_a++;
            if (c == 3) chk("sw MEM_WRITE in MEM", mwr[1], 1);
            if (c == 8) chk("beq MEM no strobe", {st[1], mrd[1], mwr[1]}, {PROC_MEM, 2'b00});
        end
        chk("MEM_WRITE total", cnt_a, 1);
        chk("sw WB strobes", {s_a[4], s_b[4]}, 2'b01);
        chk("beq WB strobes", {s_a[9], s_b[9]}, 2'b01);
        chk("sw/beq ends IDLE", s_st[10], PROC_IDLE);
        chk("sw/beq INSN_COUNT", ic1, 2);

        // HALT raised in DECODE and held, then dropped
        tick();
        halt[0] = 1'b0; ack[0] = 1'b1; insn[0] = mk(6'h0d, 6'h00);
        for (int c = 0; c < 8; c++) begin
            tick();
            halt[0] = (c >= 1 && c <= 5);
            @(negedge clk);
            s_st[c] = st[0]; s_a[c] = rfw[0];
        end
        chk("halt DECODE", s_st[1], PROC_DECODE);
        chk("halt WB", {s_st[3], s_a[3]}, {PROC_WB, 1'b1});
        chk("halt IDLE 4", s_st[4], PROC_IDLE);
        chk("halt IDLE 5", s_st[5], PROC_IDLE);
        chk("halt IDLE 6", s_st[6], PROC_IDLE);
        chk("halt release FETCH", s_st[7], PROC_FETCH);
        for (int c = 0; c < 4; c++) begin
            tick();
            halt[0] = 1'b1;
        end
        @(negedge clk);
        chk("halt second insn IDLE", st[0], PROC_IDLE);
        chk("halt INSN_COUNT", ic0, 3);

        // stall saturation and retire wrap on the 3-bit instance
        tick();
        halt[1] = 1'b0; ack[1] = 1'b0; insn[1] = mk(6'h00, 6'h21);
        for (int c = 0; c < 12; c++) begin
            tick();
            @(negedge clk);
        end
        chk("STALL_COUNT saturates", sc1, 7);
        pulses = 0;
        for (int c = 0; c < 80 && pulses < 6; c++) begin
            tick();
            ack[1] = 1'b1;
            halt[1] = (pulses >= 5);
            insn[1] = pulses[0] ? mk(6'h00, 6'h08) : mk(6'h00, 6'h21);
            @(negedge clk);
            if (pcl[1]) pulses++;
        end
        chk("wrap retire pulses", pulses, 6);
        tick();
        @(negedge clk);
        chk("wrap INSN_COUNT", ic1, 0);
        chk("wrap ends IDLE", st[1], PROC_IDLE);

        // reset during a push MEM wait
        tick();
        halt[0] = 1'b0; insn[0] = mk(6'h1b, 6'h00);
        for (int c = 0; c < 6; c++) begin
            tick();
            ack[0] = (c == 0); halt[0] = 1'b1; rst = (c != 4);
            @(negedge clk);
            s_st[c] = st[0]; s_a[c] = mwr[0];
        end
        chk("push MEM write", {s_st[3], s_a[3]}, {PROC_MEM, 1'b1});
        chk("push still waiting", s_st[4], PROC_MEM);
        chk("push reset IDLE", {s_st[5], s_a[5]}, {PROC_IDLE, 1'b0});
        chk("push reset counters", {ic0, sc0}, 0);

        // FETCH with ACK stuck low
        tick();
        halt[0] = 1'b0; ack[0] = 1'b0; insn[0] = mk(6'h08, 6'h00);
        for (int c = 0; c < 7; c++) begin
            tick();
            halt[0] = 1'b1;
            @(negedge clk);
            s_st[c] = st[0]; s_a[c] = err[0];
        end
`ifdef PROC_SEQ_MEM_TIMEOUT_EN
        chk("timeout 4th wait FETCH", {s_st[3], s_a[3]}, {PROC_FETCH, 1'b0});
        chk("timeout IDLE+ERR", {s_st[4], s_a[4]}, {PROC_IDLE, 1'b1});
        chk("timeout sticky", {s_st[6], s_a[6]}, {PROC_IDLE, 1'b1});
        chk("timeout no retire", ic0, 0);
        chk("timeout STALL_COUNT", sc0, 4);
`else
        chk("no timeout FETCH", {s_st[6], s_a[6]}, {PROC_FETCH, 1'b0});
        chk("no timeout STALL_COUNT", sc0, 6);
        chk("no timeout INSN_COUNT", ic0, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
